// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller
//
// Purpose:
//   Control end of the en/flush pairs on the IF/ID, ID/EX and EX/MEM latches,
//   plus the PC enable. It resolves halt, dcache wait, taken branch/jump,
//   data (RAW / load-use) stalls and icache wait. Per-cycle priority, highest
//   first: HALT > DWAIT > branch flush > data stall > ihit wait > RUN.
//
// Ports:
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   ihit, dhit                icache / dcache completion for this cycle
//   mem_req                   EX/MEM latch holds a load or store
//   id_rs, id_rt, id_uses_rt  source registers of the instruction in ID
//   ex_regWr, ex_dREN, ex_wsel    writer / load / destination in EX
//   mem_regWr, mem_wsel       writer / destination in MEM
//   ex_br_taken               taken branch or jump resolved in EX
//   mem_halt                  halt instruction reached EX/MEM
//   pc_en, *_en, *_flush      latch controls (combinational from state+inputs)
//   halted                    sticky halt status (registered)
//
// Configuration:
//   HAZARD_FWD_EN  defined   -> forwarding exists; stall only on load-use,
//                               exactly one cycle.
//                  undefined -> stall on any RAW against EX or MEM writers,
//                               at most MAX_STALL consecutive cycles.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MAX_STALL = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_regWr,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             mem_regWr,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic             ex_br_taken,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             halted
);

  localparam int CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {RUN, DWAIT, STALL, HALT} state_t;

  state_t           stateReg;
  logic [CNT_W-1:0] stallCntReg;
  logic             haltedReg;

  // A destination matches if it is non-zero and the ID instruction reads it.
  logic exHit, memHit, hazard;
  assign exHit  = (ex_wsel != '0) &&
                  ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
  assign memHit = (mem_wsel != '0) &&
                  ((mem_wsel == id_rs) || (id_uses_rt && (mem_wsel == id_rt)));

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load whose data is not back yet.
  localparam int STALL_LIMIT = 1;
  assign hazard = ex_dREN && ex_regWr && exHit;
  logic unusedNoFwd;
  assign unusedNoFwd = memHit & mem_regWr;
`else
  localparam int STALL_LIMIT = MAX_STALL;
  assign hazard = (ex_regWr && exHit) || (mem_regWr && memHit);
  logic unusedFwd;
  assign unusedFwd = ex_dREN;
`endif

  logic haltNow, dwaitNow, stallNow;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    haltNow     = 1'b0;
    dwaitNow    = 1'b0;
    stallNow    = 1'b0;
    if (RST) begin
      // Latches run freely while reset is held.
    end else if ((stateReg == HALT) || mem_halt) begin
      haltNow  = 1'b1;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (mem_req && !dhit) begin
      // Freeze everything; a pending branch flush stays visible on
      // ex_br_taken and is applied in the cycle dhit arrives.
      dwaitNow = 1'b1;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (ex_br_taken) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed; this also
      // overrides any stall for the (wrong-path) instruction in ID.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard && (stallCntReg < CNT_W'(STALL_LIMIT))) begin
      stallNow   = 1'b1;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign halted = haltedReg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg    <= RUN;
      stallCntReg <= '0;
      haltedReg   <= 1'b0;
    end else if (haltNow) begin
      stateReg    <= HALT;
      stallCntReg <= '0;
      haltedReg   <= 1'b1;
    end else if (dwaitNow) begin
      // Pipeline frozen: keep the stall count of an interrupted stall.
      stateReg <= DWAIT;
    end else if (stallNow) begin
      stateReg <= STALL;
      if (stallCntReg != CNT_W'(MAX_STALL))
        stallCntReg <= stallCntReg + CNT_W'(1);
    end else begin
      stateReg    <= RUN;
      stallCntReg <= '0;
    end
  end

`ifndef HAZARD_FWD_EN
  // A RAW hazard still present after MAX_STALL stall cycles means the
  // datapath is not draining as expected.
  logic stallOverrun;
  assign stallOverrun = !RST && !haltNow && !dwaitNow && !ex_br_taken &&
                        hazard && (stallCntReg == CNT_W'(MAX_STALL));
  always_ff @(posedge CLK) begin
    assert (!stallOverrun);
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// A directed section pins the reference model to hand-computed output
// vectors, then a randomized section compares the DUT against the model
// every cycle. Output vector order:
//   {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_W     = 5;
  localparam int MAX_STALL = 2;

  localparam logic [7:0] RUNV   = 8'b0110_1010;
  localparam logic [7:0] STALLV = 8'b0000_1110;
  localparam logic [7:0] FLUSHV = 8'b0111_1110;
  localparam logic [7:0] FROZV  = 8'b0000_0000;
  localparam logic [7:0] BUBV   = 8'b0011_1010;
  localparam logic [7:0] HALTV  = 8'b1000_0000;
  localparam logic [7:0] HRSTV  = 8'b1110_1010;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, mem_req;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rt;
  logic             ex_regWr, ex_dREN;
  logic [REG_W-1:0] ex_wsel;
  logic             mem_regWr;
  logic [REG_W-1:0] mem_wsel;
  logic             ex_br_taken, mem_halt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, halted;

  hazard_ctrl #(.REG_W(REG_W), .MAX_STALL(MAX_STALL)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_regWr(ex_regWr), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
    .mem_regWr(mem_regWr), .mem_wsel(mem_wsel),
    .ex_br_taken(ex_br_taken), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: sticky halt and consecutive data-stall cycles.
  bit mHalted = 1'b0;
  int mStall  = 0;

`ifdef HAZARD_FWD_EN
  localparam int LIMIT = 1;
`else
  localparam int LIMIT = MAX_STALL;
`endif

  function automatic bit reads(input logic [REG_W-1:0] r);
    return (r != 0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
  endfunction

  function automatic bit dataHazard();
`ifdef HAZARD_FWD_EN
    return ex_dREN && ex_regWr && reads(ex_wsel);
`else
    return (ex_regWr && reads(ex_wsel)) || (mem_regWr && reads(mem_wsel));
`endif
  endfunction

  // Which rule governs this cycle: 0 reset, 1 halt, 2 dwait, 3 flush,
  // 4 stall, 5 ihit bubble, 6 run.
  function automatic int rule();
    if (RST)                                   return 0;
    if (mHalted || mem_halt)                   return 1;
    if (mem_req && !dhit)                      return 2;
    if (ex_br_taken)                           return 3;
    if (dataHazard() && (mStall < LIMIT))      return 4;
    if (!ihit)                                 return 5;
    return 6;
  endfunction

  function automatic logic [7:0] expOut();
    logic [7:0] v;
    case (rule())
      1, 2:    v = FROZV;
      3:       v = FLUSHV;
      4:       v = STALLV;
      5:       v = BUBV;
      default: v = RUNV;
    endcase
    v[7] = mHalted;
    return v;
  endfunction

  task automatic modelStep();
    int r;
    r = rule();
    if (r == 0) begin
      mHalted = 1'b0; mStall = 0;
    end else if (r == 1) begin
      mHalted = 1'b1; mStall = 0;
    end else if (r == 4) begin
      if (mStall < MAX_STALL) mStall++;
    end else if (r != 2) begin
      mStall = 0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: compare mid-cycle, then advance the model at the edge.
  task automatic cycle(input string name, input logic [7:0] lit, input bit pin);
    logic [7:0] e;
    @(negedge CLK);
    e = expOut();
    if (pin) check({"model_", name}, e, lit);
    check(name, {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush}, e);
    $display("cyc %0t %s rst=%0b req=%0b dhit=%0b br=%0b halt=%0b ihit=%0b exp=%b",
             $time, name, RST, mem_req, dhit, ex_br_taken, mem_halt, ihit, e);
    @(posedge CLK);
    modelStep();
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; mem_req = 0; id_rs = 0; id_rt = 0;
    id_uses_rt = 0; ex_regWr = 0; ex_dREN = 0; ex_wsel = 0;
    mem_regWr = 0; mem_wsel = 0; ex_br_taken = 0; mem_halt = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    @(posedge CLK); #1;
    cycle("reset2", RUNV, 1'b1);
    idle();
    cycle("idle0", RUNV, 1'b1);
    cycle("idle1", RUNV, 1'b1);

    // Register 0 destination never stalls.
    ex_regWr = 1; ex_dREN = 1; ex_wsel = 0; id_rs = 0;
    mem_regWr = 1; mem_wsel = 0;
    cycle("r0_no_hazard", RUNV, 1'b1);
    idle();

`ifdef HAZARD_FWD_EN
    ex_regWr = 1; ex_dREN = 1; ex_wsel = 5; id_rs = 5;
    cycle("loaduse_s1", STALLV, 1'b1);
    cycle("loaduse_done", RUNV, 1'b1);
    idle();
`else
    ex_regWr = 1; ex_wsel = 3; id_rt = 3; id_uses_rt = 1; id_rs = 1;
    cycle("raw_s1", STALLV, 1'b1);
    ex_regWr = 0; mem_regWr = 1; mem_wsel = 3;
    cycle("raw_s2", STALLV, 1'b1);
    mem_regWr = 0;
    cycle("raw_done", RUNV, 1'b1);
    idle();
`endif

    mem_req = 1; dhit = 0; ex_br_taken = 1;
    for (int i = 0; i < 3; i++) cycle("dwait_br", FROZV, 1'b1);
    dhit = 1;
    cycle("dwait_exit_flush", FLUSHV, 1'b1);
    idle();
    cycle("after_dwait", RUNV, 1'b1);

    ex_regWr = 1; ex_dREN = 1; ex_wsel = 5; id_rs = 5; ex_br_taken = 1;
    cycle("br_beats_stall", FLUSHV, 1'b1);
    idle();
    cycle("no_stall_after_br", RUNV, 1'b1);

    ihit = 0;
    cycle("ihit_bubble", BUBV, 1'b1);
    idle();

    mem_halt = 1;
    cycle("halt_enter", FROZV, 1'b1);
    mem_halt = 0;
    for (int i = 0; i < 3; i++) cycle("halt_sticky", HALTV, 1'b1);
    RST = 1;
    cycle("halt_rst", HRSTV, 1'b1);
    RST = 0;
    cycle("halt_cleared", RUNV, 1'b1);

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      RST         = mHalted ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 149) == 0);
      mem_halt    = ($urandom_range(0, 299) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      dhit        = ($urandom_range(0, 2) != 0);
      ihit        = ($urandom_range(0, 4) != 0);
      ex_br_taken = ($urandom_range(0, 6) == 0);
      id_rs       = REG_W'($urandom_range(0, 3));
      id_rt       = REG_W'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom);
      ex_regWr    = 1'($urandom);
      ex_dREN     = 1'($urandom);
      ex_wsel     = REG_W'($urandom_range(0, 3));
      mem_regWr   = 1'($urandom);
      mem_wsel    = REG_W'($urandom_range(0, 3));
`ifndef HAZARD_FWD_EN
      // A real pipeline drains within MAX_STALL cycles; keep stimulus legal.
      if (mStall >= MAX_STALL) begin
        ex_regWr = 0; mem_regWr = 0;
      end
`endif
      cycle("rand", 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
